// File: rtl/rc5_block_scheduler_pkg.sv
// Shared types and defaults for the RC5 block scheduler: FSM state encoding,
// default parameter values and the derived timeout-counter width.
package rc5_sched_pkg;

   localparam int DEF_W       = 32;
   localparam int DEF_R       = 12;
   localparam int DEF_TIMEOUT = 256;
   localparam int DEF_CNT_W   = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      RELEASE = 2'd2,
      ERROR   = 2'd3
   } sched_state_e;

   // Wide enough to hold the value TIMEOUT itself.
   function automatic int tmo_width(input int timeout);
      return $clog2(timeout + 1);
   endfunction

endpackage

// File: rtl/rc5_block_scheduler_if.sv
// Host block stream, engine handshake and status signals of the RC5 block
// scheduler. The scheduler connects through the slave modport.
interface rc5_block_scheduler_if
   import rc5_sched_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int CNT_W = DEF_CNT_W
);
   logic             iKeyReady;
   logic             iValid;
   logic [W-1:0]     iA;
   logic [W-1:0]     iB;
   logic             oReady;
   logic             oValid;
   logic [W-1:0]     oA;
   logic [W-1:0]     oB;
   logic             iReady;
   logic             oStart;
   logic [W-1:0]     oA_eng;
   logic [W-1:0]     oB_eng;
   logic [W-1:0]     iA_eng;
   logic [W-1:0]     iB_eng;
   logic             iDone;
   logic             oErr;
   logic             iClrErr;
   logic             oAbort;
   logic [CNT_W-1:0] oBlockCount;

   modport slave (
      input  iKeyReady, iValid, iA, iB, iReady, iA_eng, iB_eng, iDone, iClrErr,
      output oReady, oValid, oA, oB, oStart, oA_eng, oB_eng, oErr, oAbort, oBlockCount
   );

   modport master (
      output iKeyReady, iValid, iA, iB, iReady, iA_eng, iB_eng, iDone, iClrErr,
      input  oReady, oValid, oA, oB, oStart, oA_eng, oB_eng, oErr, oAbort, oBlockCount
   );

endinterface

// File: rtl/rc5_block_scheduler_timeout_counter.sv
// RUN-cycle watchdog: cleared on block accept, counts while enabled, holds
// while disabled; hit_o flags the cycle in which the count reaches TIMEOUT.
module rc5_timeout_counter
   import rc5_sched_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int TW      = tmo_width(TIMEOUT)
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic hit_o
);
   localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   assign hit_o = en_i && (count_q == LAST);

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = '0;
      end else if (en_i) begin
         count_d = count_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/rc5_block_scheduler.sv
// Feeds plaintext blocks to a single RC5 engine one at a time, holds the
// engine start level while it runs and captures its result into an output register.
module rc5_block_scheduler
   import rc5_sched_pkg::*;
#(
   parameter int W       = DEF_W,
   parameter int R       = DEF_R,
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                  clk,
   input  logic                  rst,
   rc5_block_scheduler_if.slave  bus
);
   if (R < 1 || TIMEOUT < 1 || W < 1 || CNT_W < 1) begin : g_param_check
      $fatal(1, "rc5_block_scheduler: invalid parameters");
   end

   sched_state_e     state_q;
   logic             start_q;
   logic             valid_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic [W-1:0]     a_eng_q;
   logic [W-1:0]     b_eng_q;
   logic             err_q;
   logic             abort_q;
   logic [CNT_W-1:0] count_q;

   logic ready;
   logic accept;
   logic can_capture;
   logic tmo_en;
   logic tmo_hit;

   assign ready       = (state_q == IDLE) && bus.iKeyReady && !err_q;
   assign accept      = ready && bus.iValid;
   assign can_capture = !valid_q || bus.iReady;
   // A done engine waiting on a full output register must not time out.
   assign tmo_en      = (state_q == RUN) && !bus.iDone;

   rc5_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
      .clk   (clk),
      .rst   (rst),
      .clr_i (accept),
      .en_i  (tmo_en),
      .hit_o (tmo_hit)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         start_q <= 1'b0;
         valid_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         a_eng_q <= '0;
         b_eng_q <= '0;
         err_q   <= 1'b0;
         abort_q <= 1'b0;
         count_q <= '0;
      end else begin
         abort_q <= 1'b0;
         if (valid_q && bus.iReady) begin
            valid_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_eng_q <= bus.iA;
                  b_eng_q <= bus.iB;
                  start_q <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               // Losing the key outranks a result arriving in the same cycle.
               if (!bus.iKeyReady) begin
                  start_q <= 1'b0;
                  abort_q <= 1'b1;
                  state_q <= RELEASE;
               end else if (bus.iDone && can_capture) begin
                  a_q     <= bus.iA_eng;
                  b_q     <= bus.iB_eng;
                  valid_q <= 1'b1;
                  count_q <= count_q + CNT_W'(1);
                  start_q <= 1'b0;
                  state_q <= RELEASE;
               end else if (tmo_hit) begin
                  start_q <= 1'b0;
                  err_q   <= 1'b1;
                  state_q <= ERROR;
               end
            end
            RELEASE: begin
               state_q <= IDLE;
            end
            ERROR: begin
               if (bus.iClrErr) begin
                  err_q   <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.oReady      = ready;
   assign bus.oValid      = valid_q;
   assign bus.oA          = a_q;
   assign bus.oB          = b_q;
   assign bus.oStart      = start_q;
   assign bus.oA_eng      = a_eng_q;
   assign bus.oB_eng      = b_eng_q;
   assign bus.oErr        = err_q;
   assign bus.oAbort      = abort_q;
   assign bus.oBlockCount = count_q;

endmodule

// File: doc/rc5_block_scheduler.md
Name: rc5_block_scheduler

Overview:
Sequences the RC5 encryption engine over a stream of 2W-bit plaintext blocks. Accepts blocks on a valid/ready input, drives the engine's start level and operands, and captures the result when the engine reports done. Deasserts start between blocks so the engine re-initialises. Sits between the host-side block interface and the single encryption engine; the S-table key-expansion logic signals readiness through iKeyReady.

Parameters:
W, 32, data word width; a block is {A,B}, 2*W bits.
R, 12, round count; informational only, must match the engine.
TIMEOUT, 256, maximum RUN cycles allowed before iDone; counter width $clog2(TIMEOUT+1).
CNT_W, 16, width of the completed-block counter.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
iKeyReady  in  1  S-table loaded and stable
iValid  in  1  input block valid
iA  in  W  plaintext word A
iB  in  W  plaintext word B
oReady  out  1  scheduler accepts a block this cycle
oValid  out  1  result register holds a ciphertext block
oA  out  W  ciphertext word A
oB  out  W  ciphertext word B
iReady  in  1  consumer takes the result this cycle
oStart  out  1  engine start level; engine runs while high, resets while low
oA_eng  out  W  operand A to engine, stable while oStart=1
oB_eng  out  W  operand B to engine, stable while oStart=1
iA_eng  in  W  engine result A
iB_eng  in  W  engine result B
iDone  in  1  engine done; sticky high while oStart stays high
oErr  out  1  sticky timeout flag
iClrErr  in  1  clears oErr and leaves ERROR
oAbort  out  1  one-cycle pulse when a block is discarded
oBlockCount  out  CNT_W  completed blocks, wraps modulo 2^CNT_W

Behaviour:
- Reset, asynchronous: state=IDLE; oStart=0, oValid=0, oA/oB/oA_eng/oB_eng=0, oErr=0, oAbort=0, oBlockCount=0, timeout counter=0.
- oReady = (state==IDLE) && iKeyReady && !oErr. The output register does not gate oReady.
- IDLE: when iValid && oReady, latch iA/iB into oA_eng/oB_eng, clear the timeout counter, and move to RUN; oStart=1 from the next cycle.
- RUN: oStart=1; the timeout counter increments each cycle.
  - iDone=1 and (oValid=0 or iReady=1): load oA/oB from iA_eng/iB_eng, set oValid=1, increment oBlockCount, go to RELEASE.
  - iDone=1 and output register full with iReady=0: stay in RUN holding oStart=1 (engine result stays stable). The timeout counter freezes.
  - Counter reaches TIMEOUT with iDone=0: go to ERROR, set oErr=1, and discard the block.
  - iKeyReady drops: go to RELEASE, pulse oAbort for 1 cycle, and discard the block. This check has priority over iDone in the same cycle.
- RELEASE: oStart=0 for exactly 1 cycle so the engine synchronously resets; then go to IDLE.
- ERROR: oStart=0, oReady=0. On iClrErr, clear oErr and go to IDLE.
- Output handshake: oValid drops after a cycle with oValid && iReady unless a new capture occurs in that same cycle. oA/oB hold while oValid && !iReady.
- Minimum spacing between block accepts is engine latency + 2 cycles: RUN entry through RELEASE.
- State encodings and widths come from the package; there is no implicit width truncation except oBlockCount wrap.

Decomposition:
- Package rc5_sched_pkg: state encodings (IDLE, RUN, RELEASE, ERROR), default TIMEOUT, and derived widths (timeout counter width, CNT_W).
- One sub-module, rc5_timeout_counter: a clear/enable/freeze counter with a terminal flag at TIMEOUT.
- The FSM and output register stay in the top.

Test Plan:
- Stub engine asserts iDone 5 cycles after oStart rises, returns A+1/B+1. Stimulus: one block A=32'h00000010, B=32'h00000020, with iReady=1. Required: oA=32'h11, oB=32'h21, oValid=1, oStart low exactly 1 cycle after capture, oBlockCount=1.
- Real RC5-32/12 engine, all-zero key, A=B=0. Required: oA=32'hEEDBA521, oB=32'h6D8F4B15.
- Back-to-back blocks with iReady=0 held. Required: the second block's engine stays in RUN with oStart=1 and iDone=1, and no capture occurs. On iReady=1, the first result is taken and the second is captured the same cycle.
- Stub that never asserts iDone, TIMEOUT=8. Required: oErr=1 after 8 RUN cycles, oStart=0, and oReady=0 until iClrErr, then oReady=1.
- iKeyReady dropped mid-RUN. Required: oAbort pulses for 1 cycle, oValid stays 0, oBlockCount unchanged, oStart low the next cycle.
- rst asserted mid-RUN asynchronously. Required: oStart, oValid and oErr go to 0 immediately, without waiting for a clock edge; oBlockCount=0.
